// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, pending PC-update kinds,
// opcode-class constants and default widths.
package cpu_pkg;

   localparam int PC_W_DEF = 8;
   localparam int IR_W_DEF = 8;

   // Opcode classes decoded from Opcode[7:4] by the controller.
   localparam logic [3:0] OP_HALT = 4'hF;
   localparam logic [3:0] OP_JZR  = 4'h6;
   localparam logic [3:0] OP_JZI  = 4'h7;
   localparam logic [3:0] OP_JCR  = 4'h8;
   localparam logic [3:0] OP_JCI  = 4'hA;

   typedef enum logic {
      IDLE,
      WAIT
   } fetch_state_t;

   // A PC update requested while a fetch is outstanding.
   typedef enum logic [1:0] {
      PEND_NONE,
      PEND_INC,
      PEND_LOAD
   } pend_kind_t;

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector for the controller's level strobes.
module rise_detect (
   input  logic clk,
   input  logic level,
   output logic rise
);

   logic level_q;

   // Previous level is tracked in every cycle, reset included: a strobe that is
   // already high when reset releases therefore does not count as an edge.
   always_ff @(posedge clk) begin
      // NOTE: clocked state is always written with <= so every flop samples
      // pre-edge values regardless of statement order.
      level_q <= level;
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch back end: PC, instruction register and ROM req/ack port,
// driven by the controller's LoadIR/IncPC/LoadPC/SelPC strobes.
// Optional feature macro: HALT_DETECT_EN (adds sticky `halted` output that
// freezes the unit after fetching an OP_HALT-class instruction).
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              IR_W     = IR_W_DEF,
   parameter int              ACK_TMO  = 15,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            LoadIR,
   input  logic            IncPC,
   input  logic            LoadPC,
   input  logic            SelPC,
   input  logic [3:0]      RegData,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic [IR_W-1:0] imem_rdata,
   input  logic            imem_ack,
   output logic [IR_W-1:0] Opcode,
`ifdef HALT_DETECT_EN
   output logic            halted,
`endif
   output logic            ir_valid,
   output logic [PC_W-1:0] pc,
   output logic            fetch_err
);

   localparam int TMO_W = $clog2(ACK_TMO + 1);

   logic load_ir_raw, inc_pc_raw, load_pc_raw;
   logic load_ir_rise, inc_pc_rise, load_pc_rise;

   rise_detect u_rise_load_ir (.clk(clk), .level(LoadIR), .rise(load_ir_raw));
   rise_detect u_rise_inc_pc  (.clk(clk), .level(IncPC),  .rise(inc_pc_raw));
   rise_detect u_rise_load_pc (.clk(clk), .level(LoadPC), .rise(load_pc_raw));

`ifdef HALT_DETECT_EN
   assign load_ir_rise = load_ir_raw & ~halted;
   assign inc_pc_rise  = inc_pc_raw  & ~halted;
   assign load_pc_rise = load_pc_raw & ~halted;
`else
   assign load_ir_rise = load_ir_raw;
   assign inc_pc_rise  = inc_pc_raw;
   assign load_pc_rise = load_pc_raw;
`endif

   fetch_state_t     state, state_nxt;
   logic [TMO_W-1:0] tmo_cnt;
   pend_kind_t       pend_kind, pend_kind_eff;
   logic [3:0]       pend_tgt, pend_tgt_eff;
   logic [3:0]       load_src;
   logic             fetch_ok, fetch_tmo, fetch_end;

   // Jump target chosen by SelPC: immediate operand or register value.
   assign load_src  = SelPC ? Opcode[3:0] : RegData;
   assign fetch_ok  = (state == WAIT) && imem_ack;
   assign fetch_tmo = (state == WAIT) && !imem_ack && (tmo_cnt == TMO_W'(ACK_TMO - 1));
   assign fetch_end = fetch_ok || fetch_tmo;

   // The request is exactly the WAIT state, so the address cannot move under it.
   assign imem_req = (state == WAIT);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next state: launch on a LoadIR edge, return on ack or timeout.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and infers a latch.
      state_nxt = state;
      case (state)
         IDLE:    if (load_ir_rise) state_nxt = WAIT;
         WAIT:    if (fetch_end)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Merge this cycle's PC strobes into the pending slot; LoadPC outranks IncPC.
   always_comb begin
      pend_kind_eff = pend_kind;
      pend_tgt_eff  = pend_tgt;
      if (load_pc_rise) begin
         pend_kind_eff = PEND_LOAD;
         pend_tgt_eff  = load_src;
      end else if (inc_pc_rise && pend_kind != PEND_LOAD) begin
         pend_kind_eff = PEND_INC;
      end
   end

   // Datapath: PC, IR, address, timeout counter, pending update, sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= RESET_PC;
         Opcode    <= '0;
         ir_valid  <= 1'b0;
         imem_addr <= '0;
         fetch_err <= 1'b0;
         tmo_cnt   <= '0;
         pend_kind <= PEND_NONE;
         pend_tgt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load_ir_rise) begin
                  ir_valid  <= 1'b0;
                  imem_addr <= pc;
                  tmo_cnt   <= '0;
               end
               // The fetch above already latched the old pc as its address.
               if (load_pc_rise)     pc <= PC_W'(load_src);
               else if (inc_pc_rise) pc <= pc + PC_W'(1);
            end
            WAIT: begin
               if (fetch_end) begin
                  pend_kind <= PEND_NONE;
                  if (pend_kind_eff == PEND_LOAD)     pc <= PC_W'(pend_tgt_eff);
                  else if (pend_kind_eff == PEND_INC) pc <= pc + PC_W'(1);
                  if (fetch_ok) begin
                     Opcode   <= imem_rdata;
                     ir_valid <= 1'b1;
                  end else begin
                     fetch_err <= 1'b1;
                  end
               end else begin
                  pend_kind <= pend_kind_eff;
                  pend_tgt  <= pend_tgt_eff;
                  tmo_cnt   <= tmo_cnt + TMO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef HALT_DETECT_EN
   // Sticky halt: set when a completed fetch returns a halt-class instruction.
   always_ff @(posedge clk) begin
      if (reset)                                        halted <= 1'b0;
      else if (fetch_ok && imem_rdata[7:4] == OP_HALT) halted <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized strobes and ROM responses, compared every cycle to a reference model.
module tb_instr_fetch_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       LoadIR, IncPC, LoadPC, SelPC;
   logic [3:0] RegData;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic [7:0] imem_rdata;
   logic       imem_ack;
   logic [7:0] Opcode;
   logic       ir_valid;
   logic [7:0] pc;
   logic       fetch_err;
`ifdef HALT_DETECT_EN
   logic       halted;
`endif

   instr_fetch_unit dut (
      .clk        (clk),
      .reset      (reset),
      .LoadIR     (LoadIR),
      .IncPC      (IncPC),
      .LoadPC     (LoadPC),
      .SelPC      (SelPC),
      .RegData    (RegData),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ack   (imem_ack),
      .Opcode     (Opcode),
`ifdef HALT_DETECT_EN
      .halted     (halted),
`endif
      .ir_valid   (ir_valid),
      .pc         (pc),
      .fetch_err  (fetch_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: transaction-level view of the fetch unit.
   int m_pc, m_opcode, m_addr, m_waited, m_tgt;
   int m_pend;                      // 0 none, 1 increment, 2 load
   bit m_req, m_valid, m_err, m_halted;
   bit q_li, q_ip, q_lp;

   task automatic model_reset();
      m_pc = 0; m_opcode = 0; m_addr = 0; m_waited = 0; m_tgt = 0; m_pend = 0;
      m_req = 0; m_valid = 0; m_err = 0; m_halted = 0;
   endtask

   task automatic model_clock();
      bit li_r, ip_r, lp_r, done;
      int src;
      li_r = LoadIR && !q_li;
      ip_r = IncPC  && !q_ip;
      lp_r = LoadPC && !q_lp;
      q_li = LoadIR; q_ip = IncPC; q_lp = LoadPC;
      if (m_halted) begin li_r = 0; ip_r = 0; lp_r = 0; end
      src = SelPC ? (m_opcode % 16) : int'(RegData);
      if (reset) begin
         model_reset();
      end else if (!m_req) begin
         if (li_r) begin m_valid = 0; m_req = 1; m_addr = m_pc; m_waited = 0; end
         if (lp_r)      m_pc = src;
         else if (ip_r) m_pc = (m_pc + 1) % 256;
      end else begin
         if (lp_r) begin m_pend = 2; m_tgt = src; end
         else if (ip_r && m_pend != 2) m_pend = 1;
         done = 0;
         if (imem_ack) begin
            m_opcode = int'(imem_rdata); m_valid = 1; m_req = 0; done = 1;
`ifdef HALT_DETECT_EN
            if (imem_rdata / 16 == 15) m_halted = 1;
`endif
         end else begin
            m_waited++;
            if (m_waited == 15) begin m_err = 1; m_req = 0; done = 1; end
         end
         if (done) begin
            if (m_pend == 2)      m_pc = m_tgt;
            else if (m_pend == 1) m_pc = (m_pc + 1) % 256;
            m_pend = 0;
         end
      end
   endtask

   task automatic compare_all();
      check("pc",        pc,        m_pc);
      check("opcode",    Opcode,    m_opcode);
      check("ir_valid",  ir_valid,  m_valid);
      check("imem_req",  imem_req,  m_req);
      check("fetch_err", fetch_err, m_err);
      if (m_req) check("imem_addr", imem_addr, m_addr);
`ifdef HALT_DETECT_EN
      check("halted",    halted,    m_halted);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
      compare_all();
   endtask

   task automatic do_fetch(input logic [7:0] data, input int delay);
      LoadIR = 1'b1; step();
      LoadIR = 1'b0;
      repeat (delay) step();
      imem_ack = 1'b1; imem_rdata = data; step();
      imem_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1; LoadIR = 1'b0; IncPC = 1'b0; LoadPC = 1'b0; SelPC = 1'b0;
      RegData = 4'h0; imem_ack = 1'b0; imem_rdata = 8'h00;
      q_li = 0; q_ip = 0; q_lp = 0;
      model_reset();
      repeat (3) step();
      check("rst_pc", pc, 8'h00);
      check("rst_opcode", Opcode, 8'h00);
      check("rst_valid", ir_valid, 1'b0);
      check("rst_req", imem_req, 1'b0);
      check("rst_addr", imem_addr, 8'h00);
      check("rst_err", fetch_err, 1'b0);
      reset = 1'b0;

      // First fetch: ack two cycles after the request appears.
      LoadIR = 1'b1; step();
      check("req_next_cycle", imem_req, 1'b1);
      check("addr_first", imem_addr, 8'h00);
      LoadIR = 1'b0; step();
      imem_ack = 1'b1; imem_rdata = 8'hD5; step();
      imem_ack = 1'b0;
      check("fetch_opcode", Opcode, 8'hD5);
      check("fetch_valid", ir_valid, 1'b1);
      check("fetch_pc", pc, 8'h00);

      // A held IncPC counts once.
      IncPC = 1'b1; repeat (5) step();
      check("inc_held_once", pc, 8'h01);
      IncPC = 1'b0; step();

      // Walk pc to 8'hFF, then wrap.
      repeat (254) begin IncPC = 1'b1; step(); IncPC = 1'b0; step(); end
      check("pc_at_ff", pc, 8'hFF);
      IncPC = 1'b1; step();
      check("pc_wrap", pc, 8'h00);
      IncPC = 1'b0; step();

      // LoadPC sources and LoadPC/IncPC priority.
      do_fetch(8'h73, 1);
      SelPC = 1'b1; LoadPC = 1'b1; step();
      check("load_imm", pc, 8'h03);
      LoadPC = 1'b0; step();
      SelPC = 1'b0; RegData = 4'h9; LoadPC = 1'b1; step();
      check("load_reg", pc, 8'h09);
      LoadPC = 1'b0; step();
      LoadPC = 1'b1; IncPC = 1'b1; step();
      check("load_beats_inc", pc, 8'h09);
      LoadPC = 1'b0; IncPC = 1'b0; step();

      // IncPC during an outstanding fetch is deferred to the ack cycle.
      RegData = 4'h4; LoadPC = 1'b1; step(); LoadPC = 1'b0; step();
      LoadIR = 1'b1; step(); LoadIR = 1'b0;
      IncPC = 1'b1; step();
      check("pend_pc_hold", pc, 8'h04);
      IncPC = 1'b0;
      repeat (2) begin
         step();
         check("pend_pc_wait", pc, 8'h04);
         check("pend_addr", imem_addr, 8'h04);
      end
      imem_ack = 1'b1; imem_rdata = 8'h12; step(); imem_ack = 1'b0;
      check("pend_pc_applied", pc, 8'h05);
      check("pend_valid", ir_valid, 1'b1);

      // Ack timeout.
      LoadIR = 1'b1; step(); LoadIR = 1'b0;
      repeat (14) step();
      check("tmo_not_yet", fetch_err, 1'b0);
      check("tmo_req_held", imem_req, 1'b1);
      step();
      check("tmo_err", fetch_err, 1'b1);
      check("tmo_req_drop", imem_req, 1'b0);
      check("tmo_valid", ir_valid, 1'b0);
      imem_ack = 1'b1; imem_rdata = 8'h55; step(); imem_ack = 1'b0;
      check("late_ack_ignored", Opcode, 8'h12);
      reset = 1'b1; step(); reset = 1'b0;
      check("err_cleared", fetch_err, 1'b0);

`ifdef HALT_DETECT_EN
      do_fetch(8'hF0, 0);
      check("halt_set", halted, 1'b1);
      LoadIR = 1'b1; step();
      check("halt_blocks_fetch", imem_req, 1'b0);
      LoadIR = 1'b0; IncPC = 1'b1; step();
      check("halt_pc_frozen", pc, 8'h00);
      IncPC = 1'b0; reset = 1'b1; step(); reset = 1'b0;
`endif

      // Randomized strobes, ROM latency, spurious acks and occasional resets.
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 2) == 0) LoadIR = ~LoadIR;
         if ($urandom_range(0, 2) == 0) IncPC  = ~IncPC;
         if ($urandom_range(0, 2) == 0) LoadPC = ~LoadPC;
         SelPC      = 1'($urandom);
         RegData    = 4'($urandom);
         imem_rdata = 8'($urandom);
         imem_ack   = m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
